// File: rtl/data_sram_bridge_if.sv
// Split address/data handshake bus between the M-stage bridge (master)
// and a sram-like data memory (slave).
interface data_sram_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  data_sram_req;
    logic                  data_sram_wr;
    logic [1:0]            data_sram_size;
    logic [ADDR_W-1:0]     data_sram_addr;
    logic [DATA_W/8-1:0]   data_sram_wstrb;
    logic [DATA_W-1:0]     data_sram_wdata;
    logic                  data_sram_addr_ok;
    logic                  data_sram_data_ok;
    logic [DATA_W-1:0]     data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
               data_sram_wstrb, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
               data_sram_wstrb, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );
endinterface

// File: rtl/data_sram_bridge.sv
// M-stage load/store to sram-bus bridge: one transaction per memory instruction,
// pipeline stall until the data phase completes, and a read-data hold buffer.
module data_sram_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_en_M,
    input  logic                 mem_wen_M,
    input  logic [1:0]           mem_size_M,
    input  logic [ADDR_W-1:0]    mem_addr_M,
    input  logic [DATA_W-1:0]    mem_wdata_M,
    input  logic                 stall_other,
    output logic [DATA_W-1:0]    mem_rdata_M,
    output logic                 mem_stall,
    data_sram_bridge_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'd3) ? 2'd2 : size;
    endfunction

    function automatic logic [3:0] calc_wstrb(input logic wen, input logic [1:0] size,
                                              input logic [1:0] addr_lo);
        logic [3:0] strb;
        if (!wen) begin
            strb = 4'b0000;
        end else begin
            case (norm_size(size))
                2'd0:    strb = 4'b0001 << addr_lo;
                2'd1:    strb = addr_lo[1] ? 4'b1100 : 4'b0011;
                default: strb = 4'b1111;
            endcase
        end
        return strb;
    endfunction

    state_e              state_q;
    logic                wr_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          wstrb_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [1:0]          size_d;
    logic [3:0]          wstrb_d;

    // Normalised request fields derived from the M-stage inputs
    always_comb begin
        size_d  = norm_size(mem_size_M);
        wstrb_d = calc_wstrb(mem_wen_M, mem_size_M, mem_addr_M[1:0]);
    end

    // Transaction FSM, request capture and read-data buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wstrb_q <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_en_M) begin
                        wr_q    <= mem_wen_M;
                        size_q  <= size_d;
                        addr_q  <= mem_addr_M;
                        wstrb_q <= wstrb_d;
                        wdata_q <= mem_wdata_M;
                        state_q <= bus.data_sram_addr_ok ? DATA : ADDR;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ADDR: begin
                    state_q <= bus.data_sram_addr_ok ? DATA : ADDR;
                end
                DATA: begin
                    if (bus.data_sram_data_ok) begin
                        rdata_q <= bus.data_sram_rdata;
                        state_q <= stall_other ? DONE : IDLE;
                    end else begin
                        state_q <= DATA;
                    end
                end
                DONE: begin
                    state_q <= stall_other ? DONE : IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Bus request and stall; IDLE issues straight from M so there is no bubble
    always_comb begin
        bus.data_sram_req   = 1'b0;
        bus.data_sram_wr    = 1'b0;
        bus.data_sram_size  = 2'd0;
        bus.data_sram_addr  = '0;
        bus.data_sram_wstrb = 4'b0000;
        bus.data_sram_wdata = '0;
        mem_stall           = 1'b0;
        if (!rst) begin
            mem_stall = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_en_M) begin
                        bus.data_sram_req   = 1'b1;
                        bus.data_sram_wr    = mem_wen_M;
                        bus.data_sram_size  = size_d;
                        bus.data_sram_addr  = mem_addr_M;
                        bus.data_sram_wstrb = wstrb_d;
                        bus.data_sram_wdata = mem_wdata_M;
                        mem_stall           = 1'b1;
                    end else begin
                        mem_stall = 1'b0;
                    end
                end
                ADDR: begin
                    bus.data_sram_req   = 1'b1;
                    bus.data_sram_wr    = wr_q;
                    bus.data_sram_size  = size_q;
                    bus.data_sram_addr  = addr_q;
                    bus.data_sram_wstrb = wstrb_q;
                    bus.data_sram_wdata = wdata_q;
                    mem_stall           = 1'b1;
                end
                DATA: begin
                    mem_stall = ~bus.data_sram_data_ok;
                end
                default: begin
                    mem_stall = 1'b0;
                end
            endcase
        end
    end

    // Forward the completing beat, otherwise present the held buffer
    always_comb begin
        if ((state_q == DATA) && bus.data_sram_data_ok) begin
            mem_rdata_M = bus.data_sram_rdata;
        end else begin
            mem_rdata_M = rdata_q;
        end
    end

endmodule
